// File: rtl/lsu_st_pkg.sv
// Shared types and AXI constants for the LSU store sequencer.
package lsu_st_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AW     = 2'd1,
    ST_DATA   = 2'd2,
    ST_WAIT_B = 2'd3
  } st_state_e;

  localparam logic [1:0] BRESP_OKAY     = 2'b00;
  localparam logic [1:0] BRESP_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/lsu_st_fifo.sv
// Write-data skid FIFO: registered storage, head visible the cycle after push.
// D must be a power of two, at least 2.
module lsu_st_fifo #(
  parameter int W = 72,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(D);

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lsu_store_seq.sv
// Strided store sequencer: one AW, (len+1)*(num+1) W beats, num+1 B responses, then done.
module lsu_store_seq #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int ORAM_W = 12,
  parameter int FIFO_D = 2,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_awaddr,
  input  logic [7:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_burst,
  input  logic [2:0]        req_str,
  input  logic [3:0]        req_num,
  input  logic [ORAM_W-1:0] req_oram_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [STRB_W-1:0] st_strb,
  input  logic              st_vld,
  output logic              st_rdy,
  output logic [7:0]        lsu_axi_awid,
  output logic [ADDR_W-1:0] lsu_axi_awaddr,
  output logic [7:0]        lsu_axi_awlen,
  output logic [2:0]        lsu_axi_awsize,
  output logic [1:0]        lsu_axi_awburst,
  output logic [2:0]        lsu_axi_awstr,
  output logic [ORAM_W-1:0] lsu_axi_oram_addr,
  output logic              lsu_axi_awvld,
  input  logic              axi_lsu_awrdy,
  output logic [DATA_W-1:0] lsu_axi_wdata,
  output logic [STRB_W-1:0] lsu_axi_wstrb,
  output logic              lsu_axi_wlast,
  output logic              lsu_axi_wvld,
  input  logic              axi_lsu_wrdy,
  input  logic              axi_lsu_bvld,
  input  logic [1:0]        axi_lsu_bresp,
  input  logic              axi_lsu_bid,
  input  logic [ORAM_W-1:0] axi_lsu_resp_oram_addr,
  output logic              lsu_axi_brdy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state_o,
  output logic              dbg_last_bid_o,
  output logic [ORAM_W-1:0] dbg_last_resp_oram_o
);
  import lsu_st_pkg::*;

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // vld and rdy are both high; rdy never depends combinationally on vld.

  st_state_e state_q, state_d;

  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [2:0]        str_q, str_d;
  logic [3:0]        num_q, num_d;
  logic [ORAM_W-1:0] oram_q, oram_d;
  logic [7:0]        awid_q, awid_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [4:0]        burst_cnt_q, burst_cnt_d;
  logic [4:0]        resp_cnt_q, resp_cnt_d;
  logic [12:0]       acc_cnt_q, acc_cnt_d;
  logic              err_q, err_d;
  logic              bid_q, bid_d;
  logic [ORAM_W-1:0] resp_oram_q, resp_oram_d;

  logic              in_data, fifo_full, fifo_empty;
  logic              req_hs, aw_hs, st_push, w_hs, b_hs, resp_all;
  logic [12:0]       total_beats;
  logic [4:0]        resp_tgt;

  // 13 bits: 256 beats x 16 bursts = 4096 does not fit in 12.
  assign total_beats = ({5'd0, len_q} + 13'd1) * ({9'd0, num_q} + 13'd1);
  assign resp_tgt    = {1'b0, num_q} + 5'd1;
  assign resp_all    = (resp_cnt_q == resp_tgt);

  assign req_hs  = req_vld && req_rdy;
  assign aw_hs   = lsu_axi_awvld && axi_lsu_awrdy;
  assign st_push = st_vld && st_rdy;
  assign w_hs    = lsu_axi_wvld && axi_lsu_wrdy;
  assign b_hs    = axi_lsu_bvld && lsu_axi_brdy;

  lsu_st_fifo #(.W(DATA_W + STRB_W), .D(FIFO_D)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (st_push),
    .wdata_i ({st_strb, st_data}),
    .pop_i   (w_hs),
    .rdata_o ({lsu_axi_wstrb, lsu_axi_wdata}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_vld) state_d = ST_AW;
      ST_AW:     if (axi_lsu_awrdy) state_d = ST_DATA;
      ST_DATA:   if (w_hs && lsu_axi_wlast && (burst_cnt_q == {1'b0, num_q})) state_d = ST_WAIT_B;
      ST_WAIT_B: if (resp_all) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy       = (state_q == ST_IDLE);
    lsu_axi_awvld = (state_q == ST_AW);
    in_data       = (state_q == ST_DATA);
    lsu_axi_brdy  = ((state_q == ST_DATA) || (state_q == ST_WAIT_B)) && !resp_all;
    done          = (state_q == ST_WAIT_B) && resp_all;
  end

  assign st_rdy        = in_data && !fifo_full && (acc_cnt_q != total_beats);
  assign lsu_axi_wvld  = in_data && !fifo_empty;
  assign lsu_axi_wlast = (beat_cnt_q == len_q);

  always_comb begin
    awaddr_d    = awaddr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    str_d       = str_q;
    num_d       = num_q;
    oram_d      = oram_q;
    awid_d      = awid_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    err_d       = err_q;
    bid_d       = bid_q;
    resp_oram_d = resp_oram_q;
    if (req_hs) begin
      awaddr_d    = req_awaddr;
      len_d       = req_len;
      size_d      = req_size;
      burst_d     = req_burst;
      str_d       = req_str;
      num_d       = req_num;
      oram_d      = req_oram_addr;
      beat_cnt_d  = '0;
      burst_cnt_d = '0;
      resp_cnt_d  = '0;
      acc_cnt_d   = '0;
      err_d       = 1'b0;
    end
    if (aw_hs)   awid_d    = awid_q + 8'd1;
    if (st_push) acc_cnt_d = acc_cnt_q + 13'd1;
    if (w_hs) begin
      if (lsu_axi_wlast) begin
        beat_cnt_d  = '0;
        burst_cnt_d = burst_cnt_q + 5'd1;
      end else begin
        beat_cnt_d  = beat_cnt_q + 8'd1;
      end
    end
    // Responses may overlap the data phase; each one is counted as it arrives.
    if (b_hs) begin
      resp_cnt_d  = resp_cnt_q + 5'd1;
      bid_d       = axi_lsu_bid;
      resp_oram_d = axi_lsu_resp_oram_addr;
      if (axi_lsu_bresp != BRESP_OKAY) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr_q    <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      str_q       <= '0;
      num_q       <= '0;
      oram_q      <= '0;
      awid_q      <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      resp_cnt_q  <= '0;
      acc_cnt_q   <= '0;
      err_q       <= 1'b0;
      bid_q       <= 1'b0;
      resp_oram_q <= '0;
    end else begin
      awaddr_q    <= awaddr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      str_q       <= str_d;
      num_q       <= num_d;
      oram_q      <= oram_d;
      awid_q      <= awid_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      err_q       <= err_d;
      bid_q       <= bid_d;
      resp_oram_q <= resp_oram_d;
    end
  end

  assign lsu_axi_awid      = awid_q;
  assign lsu_axi_awaddr    = awaddr_q;
  assign lsu_axi_awlen     = len_q;
  assign lsu_axi_awsize    = size_q;
  assign lsu_axi_awburst   = burst_q;
  assign lsu_axi_awstr     = str_q;
  assign lsu_axi_oram_addr = oram_q;
  assign err               = err_q;

  assign dbg_state_o          = state_q;
  assign dbg_last_bid_o       = bid_q;
  assign dbg_last_resp_oram_o = resp_oram_q;

endmodule

// File: tb/tb_lsu_store_seq.sv
// Randomized bench for lsu_store_seq against a transaction-level model of one store command.
module tb_lsu_store_seq;
  import lsu_st_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;
  localparam int ORAM_W = 12;
  localparam int STRB_W = 8;
  localparam int W      = DATA_W + STRB_W;

  logic              clk, rst_n;
  logic              req_vld, req_rdy;
  logic [ADDR_W-1:0] req_awaddr;
  logic [7:0]        req_len;
  logic [2:0]        req_size, req_str;
  logic [1:0]        req_burst;
  logic [3:0]        req_num;
  logic [ORAM_W-1:0] req_oram_addr;
  logic [DATA_W-1:0] st_data;
  logic [STRB_W-1:0] st_strb;
  logic              st_vld, st_rdy;
  logic [7:0]        awid, awlen;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize, awstr;
  logic [1:0]        awburst;
  logic [ORAM_W-1:0] aw_oram;
  logic              awvld, awrdy;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast, wvld, wrdy;
  logic              bvld, bid, brdy;
  logic [1:0]        bresp;
  logic [ORAM_W-1:0] resp_oram;
  logic              done, err;
  logic [1:0]        dbg_state;
  logic              dbg_bid;
  logic [ORAM_W-1:0] dbg_resp_oram;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_awid;

  lsu_store_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_awaddr(req_awaddr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst), .req_str(req_str), .req_num(req_num),
    .req_oram_addr(req_oram_addr),
    .st_data(st_data), .st_strb(st_strb), .st_vld(st_vld), .st_rdy(st_rdy),
    .lsu_axi_awid(awid), .lsu_axi_awaddr(awaddr), .lsu_axi_awlen(awlen),
    .lsu_axi_awsize(awsize), .lsu_axi_awburst(awburst), .lsu_axi_awstr(awstr),
    .lsu_axi_oram_addr(aw_oram), .lsu_axi_awvld(awvld), .axi_lsu_awrdy(awrdy),
    .lsu_axi_wdata(wdata), .lsu_axi_wstrb(wstrb), .lsu_axi_wlast(wlast),
    .lsu_axi_wvld(wvld), .axi_lsu_wrdy(wrdy),
    .axi_lsu_bvld(bvld), .axi_lsu_bresp(bresp), .axi_lsu_bid(bid),
    .axi_lsu_resp_oram_addr(resp_oram), .lsu_axi_brdy(brdy),
    .done(done), .err(err),
    .dbg_state_o(dbg_state), .dbg_last_bid_o(dbg_bid), .dbg_last_resp_oram_o(dbg_resp_oram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_vld = 0; req_awaddr = '0; req_len = '0; req_size = '0; req_burst = '0;
    req_str = '0; req_num = '0; req_oram_addr = '0;
    st_data = '0; st_strb = '0; st_vld = 0;
    awrdy = 0; wrdy = 0; bvld = 0; bresp = BRESP_OKAY; bid = 0; resp_oram = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    exp_awid = 8'd0;
    exp_q.delete();
  endtask

  // One store command. bad_idx selects which response (0-based) returns SLVERR, -1 for none.
  // abort_at >= 0 applies reset once that many W beats have been handed over.
  task automatic run_cmd(input logic [7:0] len, input logic [3:0] num, input logic [ADDR_W-1:0] addr,
                         input int aw_delay, input int bad_idx, input int wrdy_pct,
                         input int stv_pct, input int abort_at);
    int total, accepted, w_cnt, bursts_done, resp_sent, aw_cycles, last_b_cyc, cyc;
    bit aw_done, done_seen, exp_err, st_taken, b_taken, last_exp;
    logic [ORAM_W-1:0] oram;
    logic [2:0] size, str;
    logic [W-1:0] head;
    total = (int'(len) + 1) * (int'(num) + 1);
    accepted = 0; w_cnt = 0; bursts_done = 0; resp_sent = 0; aw_cycles = 0;
    last_b_cyc = -10; cyc = 0;
    aw_done = 0; done_seen = 0; exp_err = 0; st_taken = 1; b_taken = 1;
    oram = ORAM_W'($urandom); size = 3'($urandom_range(0, 3)); str = 3'($urandom);
    exp_q.delete();

    @(negedge clk);
    #1 check("req_rdy_idle", req_rdy, 1);
    req_awaddr = addr; req_len = len; req_size = size; req_burst = AXI_BURST_INCR;
    req_str = str; req_num = num; req_oram_addr = oram; req_vld = 1;
    @(negedge clk);
    req_vld = 0;

    while (!done_seen && cyc < 3000) begin
      awrdy = (aw_cycles >= aw_delay);
      wrdy  = ($urandom_range(0, 99) < wrdy_pct);
      if (st_taken || !st_vld) begin
        st_vld  = ($urandom_range(0, 99) < stv_pct);
        st_data = {$urandom, $urandom};
        st_strb = STRB_W'($urandom);
      end
      if (b_taken || !bvld) begin
        bvld      = (bursts_done > resp_sent) && ($urandom_range(0, 99) < 60);
        bresp     = (resp_sent == bad_idx) ? BRESP_SLVERR : BRESP_OKAY;
        bid       = exp_awid[0];
        resp_oram = ORAM_W'($urandom);
      end
      #1;
      st_taken = st_vld && st_rdy;
      b_taken  = bvld && brdy;
      if (cyc == 0) begin
        check("aw_latency", awvld, 1);
        check("err_cleared", err, 0);
      end
      if (awvld) begin
        check("aw_once", aw_done, 0);
        check("awid", awid, exp_awid);
        check("awaddr", awaddr, addr);
        check("awlen", awlen, len);
        check("awsize", awsize, size);
        check("awburst", awburst, AXI_BURST_INCR);
        check("awstr", awstr, str);
        check("aw_oram", aw_oram, oram);
        if (awrdy) begin
          aw_done = 1;
          exp_awid = exp_awid + 8'd1;
          check("aw_wait_cycles", aw_cycles + 1, aw_delay + 1);
        end
        aw_cycles++;
      end
      if (wvld) check("w_before_aw", aw_done, 1);
      if (accepted >= total) check("st_over_accept", st_rdy, 0);
      if (st_taken) begin
        exp_q.push_back({st_strb, st_data});
        accepted++;
      end
      if (wvld && wrdy) begin
        if (exp_q.size() == 0) begin
          check("w_extra_beat", wvld, 0);
        end else begin
          head = exp_q.pop_front();
          last_exp = ((w_cnt + 1) % (int'(len) + 1)) == 0;
          check("wbeat", {wstrb, wdata}, head);
          check("wlast", wlast, last_exp);
          w_cnt++;
          if (last_exp) bursts_done++;
        end
      end
      if (b_taken) begin
        resp_sent++;
        if (bresp != BRESP_OKAY) exp_err = 1;
        last_b_cyc = cyc;
      end
      if (done) begin
        done_seen = 1;
        check("done_beats", w_cnt, total);
        check("done_resps", resp_sent, int'(num) + 1);
        check("done_err", err, exp_err);
        check("done_after_b", cyc, last_b_cyc + 1);
        check("fifo_drained", exp_q.size(), 0);
      end
      if (abort_at >= 0 && w_cnt == abort_at) begin
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        #1;
        check("rst_awvld", awvld, 0);
        check("rst_wvld", wvld, 0);
        check("rst_brdy", brdy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awid", awid, 0);
        rst_n = 1;
        exp_awid = 8'd0;
        @(negedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 1);
        check("rst_st_rdy", st_rdy, 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_seen, 1);
    clear_inputs();
    #1;
    check("done_pulse", done, 0);
    check("req_rdy_back", req_rdy, 1);
    if (exp_err) check("err_sticky", err, 1);
  endtask

  initial begin
    do_reset();
    #1;
    check("reset_req_rdy", req_rdy, 1);
    check("reset_awvld", awvld, 0);
    check("reset_wvld", wvld, 0);
    check("reset_brdy", brdy, 0);
    check("reset_st_rdy", st_rdy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_awid", awid, 0);

    run_cmd(8'd3, 4'd0, 10'h040, 0, -1, 100, 100, -1);
    run_cmd(8'd1, 4'd2, 10'($urandom), 0, -1, 100, 80, -1);
    run_cmd(8'd2, 4'd1, 10'($urandom), 5, -1, 100, 100, -1);
    run_cmd(8'd7, 4'd3, 10'($urandom), 1, -1, 50, 50, -1);
    run_cmd(8'd1, 4'd2, 10'($urandom), 0, 1, 100, 100, -1);
    run_cmd(8'd0, 4'd2, 10'($urandom), 0, -1, 100, 100, -1);
    run_cmd(8'd0, 4'd15, 10'($urandom), 2, 15, 70, 70, -1);
    run_cmd(8'd3, 4'd0, 10'($urandom), 0, -1, 100, 100, 2);
    run_cmd(8'd3, 4'd1, 10'($urandom), 0, -1, 100, 100, -1);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(0, 3);
      run_cmd(8'($urandom_range(0, 7)), 4'(n), 10'($urandom), $urandom_range(0, 3),
              $urandom_range(0, n + 1) - 1, $urandom_range(30, 100), $urandom_range(30, 100), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
